// File: rtl/seq_gen_001_if.sv
// Frame-request / serial-line bundle for the "001" marker transmitter.
// The requester (master) drives start/din; the transmitter (slave) drives the rest.
interface seq_gen_001_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic              busy;
    logic              dout;
    logic              done;

    modport master (output start, output din, input ready, input busy, input dout, input done);
    modport slave  (input start, input din, output ready, output busy, output dout, output done);
endinterface

// File: rtl/seq_gen_001.sv
// Serial frame transmitter: marker 0,0,1 then DATA_W payload bits MSB first,
// with an optional '1' stuffed after every payload '0'. Idle line is 1.
module seq_gen_001 #(
    parameter int DATA_W   = 8,
    parameter bit STUFF_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seq_gen_001_if.slave   bus
);
    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MARK, DATA, STUFF} state_t;

    // state_q names the bit currently on the line; dout_d is the bit for state_d.
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] sh_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign sh_next = sh_q << 1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b1;
                if (bus.start) begin
                    sh_d    = bus.din;
                    idx_d   = 2'd0;
                    state_d = MARK;
                    dout_d  = 1'b0;
                end
            end
            MARK: begin
                if (idx_q == 2'd2) begin
                    state_d = DATA;
                    cnt_d   = CNT_INIT;
                    idx_d   = 2'd0;
                    dout_d  = sh_q[DATA_W-1];
                end else begin
                    idx_d  = idx_q + 2'd1;
                    dout_d = (idx_q == 2'd1);
                end
            end
            DATA: begin
                sh_d = sh_next;
                // The counter is held across a stuff bit so STUFF still knows whether it was last.
                if (!sh_q[DATA_W-1] && STUFF_EN) begin
                    state_d = STUFF;
                    dout_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    dout_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    dout_d = sh_next[DATA_W-1];
                end
            end
            STUFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    dout_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                    cnt_d   = cnt_q - 1'b1;
                    dout_d  = sh_q[DATA_W-1];
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ready = ~busy_q;
endmodule
